// File: rtl/jk_pkg.sv
// Shared types and the JK excitation rule used by the sequence driver.
package jk_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StPulse,
    StSettle,
    StCheck,
    StDone
  } state_e;

  // Returns {J, K} that moves the FF from q to target t on the next falling ff_clk.
  function automatic logic [1:0] jk_exc(input logic q, input logic t, input logic toggle);
    logic [1:0] jk;
    unique case ({q, t})
      2'b01:   jk = toggle ? 2'b11 : 2'b10;
      2'b10:   jk = toggle ? 2'b11 : 2'b01;
      default: jk = 2'b00;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_excite.sv
// Combinational JK excitation: picks J/K to reach target t from current q.
module jk_excite
  import jk_pkg::*;
(
  input  logic q,
  input  logic t,
  input  logic toggle,
  output logic j,
  output logic k
);

  assign {j, k} = jk_exc(q, t, toggle);

endmodule

// File: rtl/jk_seq_driver.sv
// Drives J/K/ff_clk so a master-slave JK FF walks a programmed pattern, and checks q back.
module jk_seq_driver
  import jk_pkg::*;
#(
  parameter int unsigned SEQ_LEN    = 8,
  parameter int unsigned PULSE_W    = 2,
  parameter int unsigned SETTLE     = 1,
  parameter int unsigned USE_TOGGLE = 0,
  parameter int unsigned IDX_W      = $clog2(SEQ_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SEQ_LEN-1:0] pattern,
  input  logic               q_fb,
  output logic               J,
  output logic               K,
  output logic               ff_clk,
  output logic               busy,
  output logic               done,
  output logic               mismatch,
  output logic [IDX_W-1:0]   err_idx
);

  localparam int unsigned CntMax = (PULSE_W > SETTLE) ? PULSE_W : SETTLE;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0]  PulseLoad  = CntW'(PULSE_W - 1);
  localparam logic [CntW-1:0]  SettleLoad = CntW'(SETTLE - 1);
  localparam logic [IDX_W-1:0] LastIdx    = IDX_W'(SEQ_LEN - 1);
  localparam logic             Toggle     = (USE_TOGGLE != 0);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [SEQ_LEN-1:0] shadow_q, shadow_d;
  logic               j_q, j_d, k_q, k_d;
  logic               ff_clk_q, ff_clk_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               mm_q, mm_d;
  logic [IDX_W-1:0]   err_q, err_d;
  logic               exc_j, exc_k;
  logic               target;

  assign target = shadow_q[idx_q];

  jk_excite u_excite (
    .q      (q_fb),
    .t      (target),
    .toggle (Toggle),
    .j      (exc_j),
    .k      (exc_k)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    j_d      = j_q;
    k_d      = k_q;
    busy_d   = busy_q;
    mm_d     = mm_q;
    err_d    = err_q;
    // Outputs trail the state by one cycle, so J/K settle a full cycle before ff_clk rises.
    ff_clk_d = (state_q == StPulse);
    done_d   = (state_q == StDone);

    unique case (state_q)
      StIdle: begin
        j_d = 1'b0;
        k_d = 1'b0;
        if (start) begin
          shadow_d = pattern;
          idx_d    = '0;
          mm_d     = 1'b0;
          err_d    = '0;
          busy_d   = 1'b1;
          state_d  = StSetup;
        end
      end
      StSetup: begin
        j_d     = exc_j;
        k_d     = exc_k;
        cnt_d   = PulseLoad;
        state_d = StPulse;
      end
      StPulse: begin
        if (cnt_q == '0) begin
          cnt_d   = SettleLoad;
          state_d = StSettle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StSettle: begin
        if (cnt_q == '0) state_d = StCheck;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      StCheck: begin
        if (q_fb != target) begin
          mm_d    = 1'b1;
          err_d   = idx_q;
          state_d = StDone;
        end else if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = StSetup;
        end
      end
      StDone: begin
        j_d     = 1'b0;
        k_d     = 1'b0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      j_q      <= 1'b0;
      k_q      <= 1'b0;
      ff_clk_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mm_q     <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      j_q      <= j_d;
      k_q      <= k_d;
      ff_clk_q <= ff_clk_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mm_q     <= mm_d;
      err_q    <= err_d;
    end
  end

  assign J        = j_q;
  assign K        = k_q;
  assign ff_clk   = ff_clk_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign mismatch = mm_q;
  assign err_idx  = err_q;

endmodule

// File: tb/tb_jk_seq_driver.sv
// Bench: two drivers (set/reset and toggle mode) each paired with a behavioural JK FF.
module tb_jk_seq_driver;

  localparam int NS = 8;
  localparam int PW = 2;
  localparam int ST = 1;
  localparam int P  = PW + ST + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ff_clr = 1'b0;
  logic       force0 = 1'b0;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [7:0] pat0 = '0, pat1 = '0;
  logic       j0, k0, fc0, b0, d0, m0;
  logic       j1, k1, fc1, b1, d1, m1;
  logic [2:0] e0, e1;
  logic       ffq0 = 1'b0, ffq1 = 1'b0;
  logic       qfb0, qfb1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  assign qfb0 = force0 ? 1'b0 : ffq0;
  assign qfb1 = force0 ? 1'b0 : ffq1;

  always #5 clk = ~clk;

  jk_seq_driver #(.SEQ_LEN(NS), .PULSE_W(PW), .SETTLE(ST), .USE_TOGGLE(0)) dut (
    .clk(clk), .rst(rst), .start(start0), .pattern(pat0), .q_fb(qfb0),
    .J(j0), .K(k0), .ff_clk(fc0), .busy(b0), .done(d0), .mismatch(m0), .err_idx(e0)
  );

  jk_seq_driver #(.SEQ_LEN(NS), .PULSE_W(PW), .SETTLE(ST), .USE_TOGGLE(1)) dut_t (
    .clk(clk), .rst(rst), .start(start1), .pattern(pat1), .q_fb(qfb1),
    .J(j1), .K(k1), .ff_clk(fc1), .busy(b1), .done(d1), .mismatch(m1), .err_idx(e1)
  );

  // Master-slave JK FF: J/K are stable while ff_clk is high, so q resolves on the fall.
  always @(negedge fc0 or posedge ff_clr) begin
    if (ff_clr)          ffq0 <= 1'b0;
    else if (j0 && k0)   ffq0 <= ~ffq0;
    else if (j0)         ffq0 <= 1'b1;
    else if (k0)         ffq0 <= 1'b0;
  end

  always @(negedge fc1 or posedge ff_clr) begin
    if (ff_clr)          ffq1 <= 1'b0;
    else if (j1 && k1)   ffq1 <= ~ffq1;
    else if (j1)         ffq1 <= 1'b1;
    else if (k1)         ffq1 <= 1'b0;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (n=%0d t=%0t): got %0d, expected %0d", name, cyc, $time, act, exp);
    end
  endtask

  task automatic ff_clear();
    @(negedge clk);
    ff_clr = 1'b1;
    #1 ff_clr = 1'b0;
  endtask

  // Runs one pattern on driver sel and checks every output on every cycle against a
  // step-level model: step s spans P cycles, FF is assumed to reach each target.
  task automatic run(input int sel, input logic [7:0] pat, input bit frc, input bit hold,
                     output int done_at);
    int err, s_run, total, s, ph;
    logic qb, t, ej, ek, efc, eb, ed, em;
    logic aj, ak, afc, ab, ad, am;
    logic [2:0] ae;
    logic [7:0] orig;
    bit tog;
    tog  = (sel == 1);
    orig = pat;
    err  = -1;
    for (int i = 0; i < NS; i++) if (frc && orig[i] && err < 0) err = i;
    s_run   = (err < 0) ? NS : err + 1;
    total   = s_run * P + 1;
    done_at = -1;
    force0  = frc;
    if (sel == 0) pat0 = pat; else pat1 = pat;
    @(negedge clk);
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin start0 = 1'b0; start1 = 1'b0; end
    for (int n = 0; n <= total + 2; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      cyc = n;
      if (hold) begin
        if (n == 1) begin pat0 = ~orig; pat1 = ~orig; end
        if (n == total) begin start0 = 1'b0; start1 = 1'b0; end
      end
      ej = 0; ek = 0; efc = 0; eb = 0; ed = 0;
      if (n == 0) begin
        eb = 1;
      end else if (n < total) begin
        s  = (n - 1) / P;
        ph = (n - 1) % P;
        qb = frc ? 1'b0 : ((s == 0) ? 1'b0 : orig[s-1]);
        t  = orig[s];
        if (qb != t) begin
          ej = tog ? 1'b1 : t;
          ek = tog ? 1'b1 : ~t;
        end
        efc = (ph >= 1) && (ph <= PW);
        eb  = 1;
      end else begin
        ed = (n == total);
      end
      em = (err >= 0) && (n >= s_run * P);
      if (sel == 0) begin aj = j0; ak = k0; afc = fc0; ab = b0; ad = d0; am = m0; ae = e0; end
      else          begin aj = j1; ak = k1; afc = fc1; ab = b1; ad = d1; am = m1; ae = e1; end
      chk("J", aj, ej);
      chk("K", ak, ek);
      chk("ff_clk", afc, efc);
      chk("busy", ab, eb);
      chk("done", ad, ed);
      chk("mismatch", am, em);
      if (em) chk("err_idx", ae, err);
      if (ad && done_at < 0) done_at = n;
    end
    force0 = 1'b0;
  endtask

  initial begin
    int da;
    #2;
    chk("reset J", j0, 0);
    chk("reset K", k0, 0);
    chk("reset ff_clk", fc0, 0);
    chk("reset busy", b0, 0);
    chk("reset done", d0, 0);
    chk("reset mismatch", m0, 0);
    chk("reset err_idx", e0, 0);
    chk("reset toggle busy", b1, 0);
    ff_clear();
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: alternating pattern, set/reset mode
    ff_clear();
    run(0, 8'b1010_1010, 0, 0, da);
    chk("t1 done cycle", da, 41);
    chk("t1 ff q", ffq0, 1);

    // 2: all ones from q=0
    ff_clear();
    run(0, 8'hFF, 0, 0, da);
    chk("t2 ff q", ffq0, 1);

    // 3: q_fb stuck at 0 aborts at step 2
    ff_clear();
    run(0, 8'h04, 1, 0, da);
    chk("t3 done cycle", da, 16);
    chk("t3 mismatch held", m0, 1);
    chk("t3 err_idx held", e0, 2);
    chk("t3 busy low", b0, 0);

    // 4: toggle mode
    ff_clear();
    run(1, 8'h0F, 0, 0, da);
    chk("t4 done cycle", da, 41);
    chk("t4 ff q", ffq1, 0);
    chk("t4 mismatch", m1, 0);

    // 5: start held through run and DONE, pattern changed mid-run
    ff_clear();
    run(0, 8'h35, 0, 1, da);
    chk("t5 done cycle", da, 41);
    chk("t5 ff q", ffq0, 0);

    // 6: reset in 2nd PULSE cycle
    ff_clear();
    pat0 = 8'h55;
    @(negedge clk) start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("t6 ff_clk before rst", fc0, 1);
    chk("t6 J before rst", j0, 1);
    rst = 1'b1;
    #1;
    chk("t6 ff_clk", fc0, 0);
    chk("t6 J", j0, 0);
    chk("t6 K", k0, 0);
    chk("t6 busy", b0, 0);
    chk("t6 done", d0, 0);
    chk("t6 mismatch", m0, 0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t6 idle busy", b0, 0);
    chk("t6 idle ff_clk", fc0, 0);
    chk("t6 idle done", d0, 0);

    // 7: normal run after reset
    ff_clear();
    run(0, 8'h5A, 0, 0, da);
    chk("t7 done cycle", da, 41);
    chk("t7 ff q", ffq0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
